// File: rtl/l2_cache_wb.sv
// l2_cache_wb: write-back, write-allocate N-way set-associative L2 cache with true-LRU replacement.
// Optional saturating performance counters are enabled by defining L2_PERF_CNT_EN.
module l2_cache_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 256,
  parameter int BLOCK_SIZE = 8,
  parameter int NUM_WAYS   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            l1_cache_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_cache_data_in,
  input  logic                             l1_cache_read,
  input  logic                             l1_cache_write,
  output logic                             l1_cache_ready,
  output logic                             l1_block_valid,
  output logic                             l1_cache_hit,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_block_data_out,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
  output logic                             mem_read,
  output logic                             mem_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block,
  input  logic                             mem_ready
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_hits,
  output logic [31:0]                      perf_misses,
  output logic [31:0]                      perf_writebacks
`endif
);
  localparam int BW = BLOCK_SIZE * DATA_WIDTH;
  localparam int SETS = CACHE_SIZE / NUM_WAYS;
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_WIDTH - IW;
  localparam int WW = $clog2(NUM_WAYS);
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0] wdata_q;
  logic wr_q;
  logic [WW-1:0] way_q;
  logic [BW-1:0] data_q [SETS][NUM_WAYS];
  logic [TW-1:0] tag_q [SETS][NUM_WAYS];
  logic [WW-1:0] age_q [SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [SETS];
  logic [NUM_WAYS-1:0] dirty_q [SETS];
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic lk, lk_hit, vic_dirty, wb_done, rf_done, accept, wr_en, acc_en;
  logic [WW-1:0] hit_way, vic_way, acc_way, max_a, old_age;
  logic [BW-1:0] wr_blk;
  logic ready_d, valid_d, hit_d, mem_read_d, mem_write_d;
  logic [BW-1:0] blk_d, mem_data_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  assign idx = addr_q[IW-1:0];
  assign tag = addr_q[ADDR_WIDTH-1:IW];
  assign lk = state_q == LOOKUP;
  assign wb_done = state_q == WRITEBACK && mem_ready;
  assign rf_done = state_q == REFILL && mem_ready;
  assign accept = state_q == IDLE && l1_cache_ready && (l1_cache_read || l1_cache_write);
  assign vic_dirty = valid_q[idx][vic_way] && dirty_q[idx][vic_way];
  always_comb begin
    lk_hit = 1'b0;
    hit_way = '0;
    vic_way = '0;
    max_a = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        lk_hit = 1'b1;
        hit_way = WW'(w);
      end
      if (age_q[idx][w] > max_a) begin
        max_a = age_q[idx][w];
        vic_way = WW'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) if (!valid_q[idx][w]) vic_way = WW'(w);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = accept ? LOOKUP : IDLE;
      LOOKUP:    state_d = lk_hit ? RESPOND : vic_dirty ? WRITEBACK : wr_q ? RESPOND : REFILL;
      WRITEBACK: state_d = mem_ready ? (wr_q ? RESPOND : REFILL) : WRITEBACK;
      REFILL:    state_d = mem_ready ? RESPOND : REFILL;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  assign wr_en = (lk && wr_q && (lk_hit || !vic_dirty)) || (wb_done && wr_q) || rf_done;
  assign acc_en = (lk && lk_hit) || wr_en;
  assign acc_way = lk ? (lk_hit ? hit_way : vic_way) : way_q;
  assign wr_blk = rf_done ? mem_data_block : wdata_q;
  // An empty way counts as the oldest, so filling it ages every occupied way
  assign old_age = valid_q[idx][acc_way] ? age_q[idx][acc_way] : WW'(NUM_WAYS - 1);
  always_comb begin
    ready_d = state_d == IDLE;
    valid_d = state_d == RESPOND;
    hit_d = lk && lk_hit;
    blk_d = state_d == RESPOND ? ((lk && lk_hit && !wr_q) ? data_q[idx][hit_way] : wr_blk) : l1_block_data_out;
    mem_write_d = state_d == WRITEBACK;
    mem_read_d = state_d == REFILL;
    mem_addr_d = (lk && state_d == WRITEBACK) ? {tag_q[idx][vic_way], idx} : state_d == REFILL ? addr_q : mem_addr;
    mem_data_d = lk ? data_q[idx][vic_way] : mem_data_out;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1_cache_ready <= 1'b0;
      l1_block_valid <= 1'b0;
      l1_cache_hit <= 1'b0;
      l1_block_data_out <= '0;
      mem_addr <= '0;
      mem_data_out <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      l1_cache_ready <= ready_d;
      l1_block_valid <= valid_d;
      l1_cache_hit <= hit_d;
      l1_block_data_out <= blk_d;
      mem_addr <= mem_addr_d;
      mem_data_out <= mem_data_d;
      mem_read <= mem_read_d;
      mem_write <= mem_write_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= l1_cache_addr;
      wdata_q <= l1_cache_data_in;
      wr_q <= l1_cache_write;
    end
    if (lk) way_q <= acc_way;
    if (wr_en) begin
      data_q[idx][acc_way] <= wr_blk;
      tag_q[idx][acc_way] <= tag;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= '0;
      end
    end else if (acc_en) begin
      for (int w = 0; w < NUM_WAYS; w++)
        age_q[idx][w] <= WW'(w) == acc_way ? '0 : age_q[idx][w] < old_age ? age_q[idx][w] + WW'(1) : age_q[idx][w];
      if (wr_en) begin
        valid_q[idx][acc_way] <= 1'b1;
        dirty_q[idx][acc_way] <= !rf_done;
      end
    end
  end
`ifdef L2_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits <= '0;
      perf_misses <= '0;
      perf_writebacks <= '0;
    end else begin
      if (lk && lk_hit && ~&perf_hits) perf_hits <= perf_hits + 32'd1;
      if (lk && !lk_hit && ~&perf_misses) perf_misses <= perf_misses + 32'd1;
      if (wb_done && ~&perf_writebacks) perf_writebacks <= perf_writebacks + 32'd1;
    end
  end
`endif
endmodule
